// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner.
// Values queue through one pending slot and swap in only at frame end.
module display_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_bcd,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        bcd_err
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t      state;
  state_t      nxt;
  logic [CW-1:0] cnt;
  logic [15:0] disp;
  logic [15:0] pend;
  logic        pend_full;

  logic        tick;
  logic        fire;
  logic        frame_end;
  logic        swap;
  logic [15:0] disp_nxt;
  logic [3:0]  nib;
  logic        lz;
  logic        blank;
  logic [3:0]  an_nxt;
  logic        err_nxt;

  assign in_ready  = ~pend_full;
  assign tick      = (cnt == CW'(CLK_DIV - 1));
  assign fire      = in_valid & ~pend_full;
  assign frame_end = tick & (state == S3);
  assign swap      = frame_end & pend_full;
  assign disp_nxt  = swap ? pend : disp;

  always_comb begin
    nxt = S0;
    unique case (state)
      S0: nxt = S1;
      S1: nxt = S2;
      S2: nxt = S3;
      S3: nxt = S0;
    endcase
  end

  // Slot contents are derived for the state being entered, not the current one.
  always_comb begin
    nib    = disp_nxt[3:0];
    lz     = 1'b0;
    an_nxt = 4'b1110;
    unique case (nxt)
      S0: begin
        nib    = disp_nxt[3:0];
        lz     = 1'b0;
        an_nxt = 4'b1110;
      end
      S1: begin
        nib    = disp_nxt[7:4];
        lz     = (disp_nxt[15:4] == 12'h000);
        an_nxt = 4'b1101;
      end
      S2: begin
        nib    = disp_nxt[11:8];
        lz     = (disp_nxt[15:8] == 8'h00);
        an_nxt = 4'b1011;
      end
      S3: begin
        nib    = disp_nxt[15:12];
        lz     = (disp_nxt[15:12] == 4'h0);
        an_nxt = 4'b0111;
      end
    endcase
  end

  assign blank = (nib > 4'd9) | (blank_lz & lz);

  assign err_nxt = (disp_nxt[3:0]   > 4'd9) |
                   (disp_nxt[7:4]   > 4'd9) |
                   (disp_nxt[11:8]  > 4'd9) |
                   (disp_nxt[15:12] > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      state     <= S0;
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      digit     <= 4'h0;
      an        <= 4'b1110;
      bcd_err   <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        state <= nxt;
        digit <= nib;
        an    <= blank ? 4'b1111 : an_nxt;
      end
      if (swap) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (fire) begin
        pend      <= in_bcd;
        pend_full <= 1'b1;
      end
      bcd_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl at CLK_DIV=4: vector table, corner
// sequences and random traffic against an edge-count reference model.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bcd = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        bcd_err;

  display_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bcd(in_bcd), .blank_lz(blank_lz),
    .digit(digit), .an(an), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position in time is just the number of edges since release.
  int          m_n;
  logic [15:0] m_disp, m_pend;
  logic        m_full, m_err;
  logic [3:0]  exp_an, exp_dig;

  typedef struct packed {
    logic [15:0] val;
    logic        blz;
    logic [15:0] an4;
    logic [15:0] dig4;
    logic        err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t n=%0d act=%h exp=%h", nm, $time, m_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_disp = 0; m_pend = 0; m_full = 0; m_err = 0;
    exp_an = 4'b1110; exp_dig = 4'h0;
  endtask

  task automatic model_edge();
    logic [3:0] nb, one;
    logic       blk;
    int         k;
    one = 4'b0001;
    if ((m_n % 16) == 15 && m_full) begin
      m_disp = m_pend;
      m_full = 0;
    end else if (in_valid && !m_full) begin
      m_pend = in_bcd;
      m_full = 1;
    end
    m_n++;
    if (m_n % 4 == 0) begin
      k   = (m_n / 4) % 4;
      nb  = 4'(m_disp >> (4 * k));
      blk = (nb > 9) || (blank_lz && k > 0 && (m_disp >> (4 * k)) == 0);
      exp_dig = nb;
      exp_an  = blk ? 4'hF : ~(one << k);
    end
    m_err = 0;
    for (int i = 0; i < 4; i++)
      if (4'(m_disp >> (4 * i)) > 4'd9) m_err = 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("an", 16'(an), 16'(exp_an));
    chk("digit", 16'(digit), 16'(exp_dig));
    chk("in_ready", 16'(in_ready), 16'(!m_full));
    chk("bcd_err", 16'(bcd_err), 16'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    model_reset();
    repeat (3) step();
    rst_n = 1;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 200 && m_n < n; i++) step();
  endtask

  initial begin
    int cnt1;
    tbl[0] = '{16'h1234, 1'b0, 16'h7BDE, 16'h1234, 1'b0};
    tbl[1] = '{16'h0070, 1'b1, 16'hFFDE, 16'h0070, 1'b0};
    tbl[2] = '{16'h12A4, 1'b0, 16'h7BFE, 16'h12A4, 1'b1};
    tbl[3] = '{16'h0000, 1'b1, 16'hFFFE, 16'h0000, 1'b0};
    tbl[4] = '{16'h0000, 1'b0, 16'h7BDE, 16'h0000, 1'b0};
    tbl[5] = '{16'h0F05, 1'b1, 16'hFFDE, 16'h0F05, 1'b1};
    tbl[6] = '{16'h1A34, 1'b0, 16'h7FDE, 16'h1A34, 1'b1};
    tbl[7] = '{16'h9999, 1'b1, 16'h7BDE, 16'h9999, 1'b0};
    tbl[8] = '{16'h0100, 1'b1, 16'hFBDE, 16'h0100, 1'b0};

    do_reset();
    run_to(8);

    // Table: offer on edge 1, displayed from edge 16, check each slot.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      blank_lz = tbl[v].blz;
      in_bcd   = tbl[v].val;
      in_valid = 1;
      step();
      in_valid = 0;
      for (int i = 0; i < 40 && m_n < 32; i++) begin
        step();
        if (m_n >= 16 && m_n % 4 == 1) begin
          int s;
          s = (m_n - 16) / 4;
          chk("tbl_an", 16'(an), 16'(4'(tbl[v].an4 >> (4 * s))));
          chk("tbl_digit", 16'(digit), 16'(4'(tbl[v].dig4 >> (4 * s))));
          chk("tbl_err", 16'(bcd_err), 16'(tbl[v].err));
        end
      end
    end

    // Back-to-back offers with in_valid held high.
    do_reset();
    blank_lz = 0;
    in_bcd   = 16'h1111;
    in_valid = 1;
    step();
    chk("b2b_stall", 16'(in_ready), 16'd0);
    in_bcd = 16'h2222;
    cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (digit == 4'd1) cnt1++;
    end
    in_valid = 0;
    chk("b2b_frame_len", 16'(cnt1), 16'd16);
    chk("b2b_second", 16'(digit), 16'd2);

    // Reset pulse in S2 with a value pending.
    do_reset();
    in_bcd   = 16'h12A4;
    in_valid = 1;
    step();
    in_valid = 0;
    run_to(20);
    in_bcd   = 16'h5678;
    in_valid = 1;
    step();
    in_valid = 0;
    run_to(25);
    chk("pre_rst_pend", 16'(in_ready), 16'd0);
    rst_n = 0;
    #2;
    chk("arst_an", 16'(an), 16'hE);
    chk("arst_digit", 16'(digit), 16'h0);
    chk("arst_ready", 16'(in_ready), 16'd1);
    chk("arst_err", 16'(bcd_err), 16'd0);
    do_reset();
    run_to(40);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      for (int j = 0; j < 4; j++)
        v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0
                      : 4'($urandom_range(0, 11));
      in_bcd   = v;
      in_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
